// File: rtl/clk_monitor_pkg.sv
// Shared definitions for the slow-clock monitor: mode/period mapping, FSM
// states and the stall threshold also used by the clock manager.
package clk_monitor_pkg;

  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int MODE_W          = 3;
  localparam int MODE_COUNT      = 8;
  localparam int PERIOD_W        = 9;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = 9'd511;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [MODE_W-1:0] mode;
  } decode_t;

  // Mode m selects a slow clock of 2^(m+1) base cycles.
  function automatic logic [PERIOD_W-1:0] mode_period(input logic [MODE_W-1:0] m);
    logic [PERIOD_W-1:0] one;
    logic [MODE_W:0]     sh;
    one = {{(PERIOD_W-1){1'b0}}, 1'b1};
    sh  = {1'b0, m} + {{MODE_W{1'b0}}, 1'b1};
    return one << sh;
  endfunction

  function automatic decode_t decode_period(input logic [PERIOD_W-1:0] p);
    decode_t d;
    d.valid = 1'b0;
    d.mode  = '0;
    for (int i = MODE_COUNT - 1; i >= 0; i--) begin
      if (p == mode_period(MODE_W'(i))) begin
        d.valid = 1'b1;
        d.mode  = MODE_W'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/clk_monitor_edge_sync.sv
// Two-flop synchronizer followed by a previous-value register; rise_o is a
// one-cycle strobe on each synchronized 0->1 transition of d_i.
module clk_monitor_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/clk_monitor.sv
// Measures the period of a slow clock sampled as data, decodes it back to a
// mode code, tracks lock and flags stall or disagreement with the programmed mode.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int CNT_W   = 11,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_in,
  input  logic [MODE_W-1:0]   prog_expected,
  output logic [MODE_W-1:0]   mode_meas,
  output logic [PERIOD_W-1:0] period,
  output logic                meas_valid,
  output logic                locked,
  output logic                mismatch,
  output logic                timeout,
  output state_e              dbg_state
);

  // meas_valid is a single-cycle strobe with no back-pressure: period,
  // mode_meas and locked are meaningful in that cycle and hold until the next one.

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

  logic rise;

  clk_monitor_edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (clk_in),
    .rise_o (rise)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                meas_valid_q, meas_valid_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;
  logic                mismatch_q, mismatch_d;
  logic                cand_valid_q, cand_valid_d;
  logic [MODE_W-1:0]   cand_mode_q, cand_mode_d;

  logic [PERIOD_W-1:0] period_sat;
  decode_t             dec;
  logic                timeout_hit;

  // CNT_W is at least PERIOD_W, so the low slice is exact below saturation.
  always_comb begin
    if (32'(cnt_q) > 32'(PERIOD_MAX)) period_sat = PERIOD_MAX;
    else                              period_sat = cnt_q[PERIOD_W-1:0];
  end

  assign dec         = decode_period(period_sat);
  assign timeout_hit = ~rise & (cnt_q == CNT_TIMEOUT);

  always_comb begin
    cnt_d = cnt_q;
    if (rise)                 cnt_d = CNT_ONE;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    cand_valid_d = cand_valid_q;
    cand_mode_d  = cand_mode_q;

    if (rise) begin
      timeout_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // First edge is only a reference; the count behind it is meaningless.
          state_d      = ST_MEASURE;
          locked_d     = 1'b0;
          cand_valid_d = 1'b0;
        end
        ST_MEASURE: begin
          meas_valid_d = 1'b1;
          period_d     = period_sat;
          if (dec.valid) mode_d = dec.mode;
          if (dec.valid && cand_valid_q && (dec.mode == cand_mode_q)) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end
          cand_valid_d = dec.valid;
          cand_mode_d  = dec.mode;
        end
        ST_LOCKED: begin
          meas_valid_d = 1'b1;
          period_d     = period_sat;
          if (dec.valid) mode_d = dec.mode;
          if (!dec.valid || (dec.mode != mode_q)) begin
            state_d      = ST_MEASURE;
            locked_d     = 1'b0;
            cand_valid_d = dec.valid;
            cand_mode_d  = dec.mode;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
        end
      endcase
    end else if (timeout_hit) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b1;
      locked_d  = 1'b0;
    end
  end

  assign mismatch_d = locked_q & (mode_q != prog_expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mode_q       <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      cand_valid_q <= 1'b0;
      cand_mode_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      mismatch_q   <= mismatch_d;
      cand_valid_q <= cand_valid_d;
      cand_mode_q  <= cand_mode_d;
    end
  end

  assign mode_meas  = mode_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: drives a synchronous slow clock, predicts every
// measurement from rise-to-rise spacing, and scores outputs on each meas_valid.
`timescale 1ns/1ps
module tb_clk_monitor;
  import clk_monitor_pkg::*;

  localparam int CNT_W   = 11;
  localparam int TIMEOUT = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clk_in;
  logic [2:0] prog_expected;
  logic [2:0] mode_meas;
  logic [8:0] period;
  logic meas_valid, locked, mismatch, timeout;
  state_e dbg_state;

  always #5 clk = ~clk;

  clk_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_in        (clk_in),
    .prog_expected (prog_expected),
    .mode_meas     (mode_meas),
    .period        (period),
    .meas_valid    (meas_valid),
    .locked        (locked),
    .mismatch      (mismatch),
    .timeout       (timeout),
    .dbg_state     (dbg_state)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  // Expected item: {locked, mode_meas, period}
  logic [12:0] exp_q[$];
  bit have_ref;
  int since_rise;
  bit prev_legal;
  int prev_mode;
  int last_mode;

  function automatic bit legal_mode(input int p, output int m);
    m = 0;
    for (int k = 0; k < 8; k++) begin
      if (p == (2 << k)) begin
        m = k;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    have_ref   = 1'b0;
    prev_legal = 1'b0;
    prev_mode  = 0;
    last_mode  = 0;
    since_rise = 0;
    exp_q.delete();
  endtask

  // Called at every clk_in rise; the spacing since the previous rise is the measurement.
  task automatic model_rise();
    bit ok, lk;
    int m;
    logic [8:0] ps;
    if (have_ref && since_rise <= TIMEOUT) begin
      ok = legal_mode(since_rise, m);
      lk = ok && prev_legal && (m == prev_mode);
      if (ok) last_mode = m;
      prev_legal = ok;
      prev_mode  = m;
      ps = (since_rise > 511) ? 9'd511 : 9'(since_rise);
      exp_q.push_back({lk, 3'(last_mode), ps});
    end else begin
      prev_legal = 1'b0;
    end
    have_ref   = 1'b1;
    since_rise = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    since_rise++;
  endtask

  task automatic drive_period(input int p);
    int h;
    h = p / 2;
    clk_in = 1'b1;
    model_rise();
    repeat (h) tick();
    clk_in = 1'b0;
    repeat (p - h) tick();
  endtask

  task automatic idle_low(input int n);
    clk_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic lock_at(input int m);
    prog_expected = 3'(m);
    repeat (3) drive_period(2 << m);
    idle_low(4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  bit mm_pending = 1'b0;
  logic mm_exp;

  always @(negedge clk) begin
    logic [12:0] e;
    if (rst) begin
      mm_pending = 1'b0;
    end else begin
      if (mm_pending) begin
        check("mismatch_after_meas", 32'(mismatch), 32'(mm_exp));
        mm_pending = 1'b0;
      end
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_meas_valid", 32'(meas_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_period", 32'(period), 32'(e[8:0]));
          check("sb_mode_meas", 32'(mode_meas), 32'(e[11:9]));
          check("sb_locked", 32'(locked), 32'(e[12]));
          mm_pending = 1'b1;
          mm_exp = e[12] && (e[11:9] != prog_expected);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mode_meas"}, 32'(mode_meas), 32'd0);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clk_in = 1'b0;
    prog_expected = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // Basic lock at mode 3
    lock_at(3);
    check("basic_locked", 32'(locked), 32'd1);
    check("basic_mode", 32'(mode_meas), 32'd3);
    check("basic_period", 32'(period), 32'd16);
    check("basic_mismatch", 32'(mismatch), 32'd0);

    // Mode sweep 0..7
    for (int m = 0; m < 8; m++) begin
      lock_at(m);
      check("sweep_locked", 32'(locked), 32'd1);
      check("sweep_period", 32'(period), 32'(2 << m));
      check("sweep_mode", 32'(mode_meas), 32'(m));
    end

    // Stall from mode 7
    while (since_rise < TIMEOUT - 2) tick();
    check("stall_timeout_early", 32'(timeout), 32'd0);
    check("stall_locked_early", 32'(locked), 32'd1);
    while (since_rise < TIMEOUT + 6) tick();
    check("stall_timeout", 32'(timeout), 32'd1);
    check("stall_locked", 32'(locked), 32'd0);
    check("stall_state", 32'(dbg_state), 32'(ST_IDLE));
    prog_expected = 3'd3;
    drive_period(16);
    check("restart_timeout_clear", 32'(timeout), 32'd0);
    check("restart_not_locked", 32'(locked), 32'd0);
    repeat (2) drive_period(16);
    idle_low(4);
    check("restart_relocked", 32'(locked), 32'd1);

    // Programmed mismatch
    lock_at(5);
    check("mm_locked5", 32'(locked), 32'd1);
    prog_expected = 3'd2;
    check("mm_not_yet", 32'(mismatch), 32'd0);
    tick();
    check("mm_raised", 32'(mismatch), 32'd1);
    repeat (3) drive_period(8);
    idle_low(4);
    check("mm_relock", 32'(locked), 32'd1);
    check("mm_mode2", 32'(mode_meas), 32'd2);
    check("mm_cleared", 32'(mismatch), 32'd0);

    // Invalid period 12
    lock_at(4);
    repeat (5) drive_period(12);
    idle_low(4);
    check("inv_locked", 32'(locked), 32'd0);
    check("inv_mode_held", 32'(mode_meas), 32'd4);
    check("inv_period", 32'(period), 32'd12);

    // Saturated period
    drive_period(700);
    drive_period(700);
    drive_period(2);
    idle_low(4);
    check("sat_period", 32'(period), 32'd511);

    // Randomized periods and programmed modes
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) prog_expected = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        int m, n;
        m = $urandom_range(0, 7);
        n = $urandom_range(1, 4);
        repeat (n) drive_period(2 << m);
      end else begin
        drive_period($urandom_range(3, 300));
      end
    end
    idle_low(4);

    // Reset mid-operation
    lock_at(3);
    check("q_empty_before_reset", 32'(exp_q.size()), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) drive_period(16);
    check("midrst_not_locked_2", 32'(locked), 32'd0);
    drive_period(16);
    idle_low(4);
    check("midrst_locked_3", 32'(locked), 32'd1);
    check("midrst_mode", 32'(mode_meas), 32'd3);

    drain();
    idle_low(2);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
